// File: rtl/matmul_pkg.sv
// Shared types and width helper for the parameterised matrix multiplier.
package matmul_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MAC,
      ST_EMIT,
      ST_DONE
   } state_t;

   // Result width: full product width plus growth from summing dim products.
   function automatic int ow_width(input int dw, input int dim);
      return 2 * dw + $clog2(dim);
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Multiply-accumulate slice: one DW x DW product per enabled cycle into an OW accumulator.
module mac_unit #(
   parameter int DW     = 8,
   parameter int OW     = 17,
   parameter int SIGNED = 0
) (
   input  logic          CLK,
   input  logic          NRST,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [OW-1:0] acc
);

   logic          a_sign;
   logic          b_sign;
   logic [OW-1:0] a_ext;
   logic [OW-1:0] b_ext;
   logic [OW-1:0] prod;

   // Extending to OW first makes the truncated product correct for both signednesses.
   always_comb begin
      a_sign = (SIGNED != 0) & a[DW-1];
      b_sign = (SIGNED != 0) & b[DW-1];
      a_ext  = {{(OW-DW){a_sign}}, a};
      b_ext  = {{(OW-DW){b_sign}}, b};
      prod   = a_ext * b_ext;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         acc <= '0;
      end else if (en) begin
         acc <= (clr ? '0 : acc) + prod;
      end else if (clr) begin
         acc <= '0;
      end
   end

endmodule

// File: rtl/matrix_multiplier_param.sv
// Square matrix multiplier: streams A/B in row-major, then emits C = A*B one element per strobe.
module matrix_multiplier_param
   import matmul_pkg::*;
#(
   parameter  int DW     = 8,
   parameter  int DIM    = 2,
   parameter  int SIGNED = 0,
   localparam int OW     = ow_width(DW, DIM)
) (
   input  logic          CLK,
   input  logic          NRST,
   input  logic          start,
   input  logic          in_valid,
   input  logic [DW-1:0] A,
   input  logic [DW-1:0] B,
   output logic          in_ready,
   output logic          busy,
   output logic [OW-1:0] OUT,
   output logic          OUT_STROBE,
   output logic          done
);

   localparam int N  = DIM * DIM;
   localparam int KW = $clog2(N);
   localparam int IW = $clog2(DIM);

   state_t        state;
   state_t        state_nxt;
   logic [KW-1:0] k;
   logic [IW-1:0] i;
   logic [IW-1:0] j;
   logic [IW-1:0] t;
   logic [DW-1:0] a_mem [N];
   logic [DW-1:0] b_mem [N];
   logic [KW-1:0] a_idx;
   logic [KW-1:0] b_idx;
   logic [OW-1:0] acc;
   logic [OW-1:0] out_hold;
   logic          last_pair;
   logic          last_t;
   logic          last_col;
   logic          last_row;
   logic          mac_clr;
   logic          mac_en;

   always_comb begin
      last_pair = (k == KW'(N - 1));
      last_t    = (t == IW'(DIM - 1));
      last_col  = (j == IW'(DIM - 1));
      last_row  = (i == IW'(DIM - 1));
      a_idx     = KW'(int'(i) * DIM + int'(t));
      b_idx     = KW'(int'(t) * DIM + int'(j));
      mac_en    = (state == ST_MAC);
      mac_clr   = mac_en && (t == '0);
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: next state is defaulted before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_LOAD;
         ST_LOAD: if (in_valid && last_pair) state_nxt = ST_MAC;
         ST_MAC:  if (last_t) state_nxt = ST_EMIT;
         ST_EMIT: state_nxt = (last_row && last_col) ? ST_DONE : ST_MAC;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         k <= '0;
         i <= '0;
         j <= '0;
         t <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               k <= '0;
               i <= '0;
               j <= '0;
               t <= '0;
            end
            ST_LOAD: if (in_valid) k <= last_pair ? '0 : k + KW'(1);
            ST_MAC:  t <= last_t ? '0 : t + IW'(1);
            ST_EMIT: begin
               if (last_col) begin
                  j <= '0;
                  i <= last_row ? '0 : i + IW'(1);
               end else begin
                  j <= j + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: operand storage has no reset; every job rewrites all entries before they are read.
   always_ff @(posedge CLK) begin
      if (state == ST_LOAD && in_valid) begin
         a_mem[k] <= A;
         b_mem[k] <= B;
      end
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         out_hold <= '0;
      end else if (state == ST_EMIT) begin
         out_hold <= acc;
      end
   end

   mac_unit #(
      .DW     (DW),
      .OW     (OW),
      .SIGNED (SIGNED)
   ) u_mac (
      .CLK  (CLK),
      .NRST (NRST),
      .clr  (mac_clr),
      .en   (mac_en),
      .a    (a_mem[a_idx]),
      .b    (b_mem[b_idx]),
      .acc  (acc)
   );

   // The accumulator is stable during EMIT, so OUT shows it directly and then holds it.
   assign OUT        = (state == ST_EMIT) ? acc : out_hold;
   assign OUT_STROBE = (state == ST_EMIT);
   assign done       = (state == ST_DONE);
   assign busy       = (state != ST_IDLE);
   assign in_ready   = (state == ST_LOAD);

endmodule

// File: doc/matrix_multiplier_param.md
MATRIX_MULTIPLIER_PARAM -- requirements
Module: matrix_multiplier_param

Interface
REQ-001 Parameter DW, default 8: element width of A and B, legal 2..16.
REQ-002 Parameter DIM, default 2: square matrix dimension, legal 2..4.
REQ-003 Parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands and result.
REQ-004 Derived constant OW = 2*DW + clog2(DIM): result width, 17 at defaults.
REQ-005 One clock; reset is asynchronous and active-low, ports CLK and NRST.
REQ-006 Port CLK, input, 1 bit: clock; all state updates on its rising edge.
REQ-007 Port NRST, input, 1 bit: asynchronous active-low reset.
REQ-008 Port start, input, 1 bit: begin a new job; sampled only in IDLE.
REQ-009 Port in_valid, input, 1 bit: A/B element pair present.
REQ-010 Port A, input, DW bits: element of matrix A, row-major order.
REQ-011 Port B, input, DW bits: element of matrix B, row-major order.
REQ-012 Port in_ready, output, 1 bit: high only in LOAD.
REQ-013 Port busy, output, 1 bit: high in every state except IDLE.
REQ-014 Port OUT, output, OW bits: current C element, held between strobes.
REQ-015 Port OUT_STROBE, output, 1 bit: one-cycle pulse marking a new valid OUT.
REQ-016 Port done, output, 1 bit: one-cycle pulse at job end.

Function
REQ-017 FSM states: IDLE, LOAD, MAC, EMIT, DONE.
REQ-018 IDLE -> LOAD on start=1; start in any other state is ignored.
REQ-019 LOAD: each cycle with in_valid=1 stores A into a[k/DIM][k%DIM] and B into b[k/DIM][k%DIM], k=0..DIM*DIM-1; in_valid=0 stalls without limit.
REQ-020 in_valid in IDLE, including the start cycle, is not captured.
REQ-021 LOAD -> MAC in the cycle after pair k=DIM*DIM-1 is captured.
REQ-022 MAC: for element (i,j), accumulator is cleared on entry, then over DIM cycles acc += a[i][t]*b[t][j], t=0..DIM-1.
REQ-023 Products and accumulation use full OW width, signed or unsigned per SIGNED; no overflow or saturation is possible.
REQ-024 MAC -> EMIT after DIM cycles; EMIT lasts one cycle: OUT = acc, OUT_STROBE = 1.
REQ-025 Elements are emitted row-major, (0,0) first; EMIT -> MAC for the next element, EMIT of the last element -> DONE.
REQ-026 Compute latency from the first MAC cycle to the last strobe is DIM*DIM*(DIM+1) cycles.
REQ-027 DONE lasts one cycle with done = 1, then goes to IDLE; start in that IDLE cycle begins the next job.
REQ-028 OUT keeps its last value through DONE and IDLE until the next EMIT.

Reset
REQ-029 NRST=0 immediately forces IDLE; OUT = 0, OUT_STROBE = 0, done = 0, busy = 0, in_ready = 0, element counters and accumulator = 0.
REQ-030 Reset mid-job abandons the job; no strobe or done follows.
REQ-031 Matrix storage arrays need no reset and are fully rewritten by every LOAD.

Structure
REQ-032 Package matmul_pkg holds the FSM state enum and the OW width function.
REQ-033 Sub-module mac_unit, parameterised by DW, OW and SIGNED, holds the multiplier, accumulator, clear and enable.
REQ-034 Top level holds the FSM, the index counters i, j and t, and the two DIM*DIM register arrays.

Verification
REQ-035 DW=8, DIM=2, SIGNED=0: A = 1,2,3,4 and B = 5,6,7,8 -> strobes with OUT = 19, 22, 43, 50, then done; 12 cycles from the first MAC to the last strobe.
REQ-036 DW=8, DIM=2, SIGNED=0: all elements 255 -> four strobes, each with OUT = 130050 (17 bits, no overflow).
REQ-037 DW=8, DIM=2, SIGNED=1: A = -128 x4 and B = -128 x4 -> OUT = 32768 x4; A = -1,2,3,-4 and B = 1,0,0,1 -> OUT = -1, 2, 3, -4.
REQ-038 DW=8, DIM=3: A = identity, B = 1..9 -> OUT = 1..9 in order; in_valid toggled 1,0,0,1 during LOAD -> identical result with only the extra stall cycles.
REQ-039 NRST pulsed low after the 3rd captured pair -> all outputs 0 immediately; a fresh job afterwards gives the correct result.
REQ-040 start held high throughout a job -> no restart mid-job; the next job begins in the IDLE cycle after done.
